average_filter_scheduler: RTL and testbench
===========================================

# average_filter_scheduler

Time-division scheduler that shares one two-tap averaging datapath between NUM_CH independent sample sources. A round-robin arbiter accepts at most one sample per cycle from the requesting channels. It keeps a separate previous-sample history for each channel and feeds the shared datapath, which computes (current + previous) >>> 1. Each result is emitted with a channel tag. It sits between multi-channel ADC/front-end producers and per-channel downstream consumers.

## Interface
- DATA_WIDTH, 8, signed sample width
- NUM_CH, 4, number of requesting channels, 2..16, need not be a power of two
- CH_W, derived as clog2(NUM_CH) and not overridable; width of the channel tag
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- i_req  in  NUM_CH  per-channel request; held high with data stable until granted
- i_data  in  NUM_CH*DATA_WIDTH  packed signed samples, channel k at bits [k*DATA_WIDTH +: DATA_WIDTH]
- i_clear  in  1  one-cycle pulse; zeroes all channel histories
- o_grant  out  NUM_CH  one-hot, combinational; the sample of the granted channel is accepted this cycle
- o_ce  out  1  result valid strobe, one cycle per result
- o_data  out  DATA_WIDTH  signed averaged result
- o_ch  out  CH_W  channel that o_data belongs to

## Operation
- Arbitration: round-robin priority pointer ptr. The first requesting channel at or after ptr, searched upward with wrap at NUM_CH-1 → 0, is granted.
  - On a grant to channel g, ptr <= (g+1) mod NUM_CH.
  - ptr holds when there is no request.
  - o_grant is all-zero when i_req is zero or reset is high.
- History: hist[NUM_CH] of DATA_WIDTH bits, reset to 0. On a grant to g:
  - The sum stage reads hist[g].
  - hist[g] <= i_data[g].
  - Other channels are untouched.
- Sum stage (registered on grant): sum_ff (DATA_WIDTH+1 bits, signed) <= sext(i_data[g]) + sext(hist[g]); ch_ff <= g; sum_ce <= 1. With no grant, sum_ce <= 0 and sum_ff and ch_ff hold.
- Output stage: when sum_ce is high, o_data <= sum_ff[DATA_WIDTH:1], o_ch <= ch_ff and o_ce <= 1. Otherwise o_ce <= 0 and o_data/o_ch hold.
  - Taking sum_ff[DATA_WIDTH:1] is an arithmetic shift that floors toward −inf. It never overflows.
- i_clear: every hist entry <= 0 on the next edge.
  - If i_clear coincides with a grant to g, the sum stage uses 0 as the history of g.
  - hist[g] still takes i_data[g], because the write wins over the clear for that entry.
  - In-flight pipeline contents and ptr are unaffected.
- First sample of any channel after reset or clear averages with 0, giving i_data/2 floored.

## Timing
- Grant and acceptance occur in the same cycle (cycle N). o_ce and o_data/o_ch for that sample are valid in cycle N+2. Latency is fixed at 2.
- Throughput is one sample per cycle aggregate. With all NUM_CH channels requesting, each channel is served exactly once per NUM_CH cycles.
- Result order equals grant order. There is no backpressure on the output.
- Reset values: ptr=0, every hist entry 0, sum_ce=0, sum_ff=0, ch_ff=0, o_ce=0, o_data=0, o_ch=0, o_grant=0.
- Reset mid-operation: every pipeline sample in flight is discarded, and o_ce is 0 on the cycle after reset is sampled. The first grant after release goes to the lowest requesting channel.
- A channel that drops i_req before being granted is skipped and its sample is not consumed.

## Structure
- Shared package average_filter_pkg: clog2 constant function and the CH_W derivation. No other shared typedefs are needed.
- Sub-module rr_arbiter (parameter N): inputs req and an advance strobe; outputs a one-hot grant and the registered ptr. It is reusable for other shared filter datapaths.
- Top level holds the history array, the two pipeline stages and the clear logic.

## Test plan
- NUM_CH=4, DATA_WIDTH=8, only ch0 requests, samples 10, 20, −6 → o_data 5, 15, 7 two cycles after each grant, o_ch=0.
- All four channels request continuously from reset release → o_grant sequence 0001, 0010, 0100, 1000, 0001…, and o_ch 0,1,2,3,0… lagging by 2 cycles with o_ce high every cycle.
- Channel isolation: ch1 sends 100, 100 and ch2 sends −100, −100, interleaved → ch1 results 50, 100 and ch2 results −50, −100.
- Extremes and rounding:
  - ch0 sends −1 first → −1.
  - ch1 sends 127 then 127 → 63, 127.
  - ch2 sends −128 then −128 → −64, −128.
- Clear collision: hist[3]=40, i_clear pulsed in the same cycle ch3 is granted with 20 → result 10. The next ch3 sample of 20 → 20, and the next ch0 sample 8 → 4.
- Reset with the pipeline full of 4-channel traffic → o_ce 0 the following cycle and all outputs 0. After release, ch2 alone requesting 6 → grant ch2, result 3.

Source files
------------

// File: rtl/average_filter_pkg.sv
// Shared constants and helpers for the time-shared averaging filter.
package average_filter_pkg;

  // Ceiling log2 for elaboration-time width derivation.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    int unsigned p;
    r = 0;
    p = 1;
    while (p < v) begin
      p = p << 1;
      r = r + 1;
    end
    return r;
  endfunction

  // Channel tag width; at least one bit so a single-bit tag still exists.
  function automatic int unsigned ch_width(input int unsigned n);
    return (n < 2) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/average_filter_scheduler_if.sv
// Producer/consumer bus of the averaging scheduler.
interface average_filter_scheduler_if
  import average_filter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned NUM_CH     = 4
);
  localparam int unsigned CH_W = ch_width(NUM_CH);

  logic [NUM_CH-1:0]            i_req;
  logic [NUM_CH*DATA_WIDTH-1:0] i_data;
  logic                         i_clear;
  logic [NUM_CH-1:0]            o_grant;
  logic                         o_ce;
  logic [DATA_WIDTH-1:0]        o_data;
  logic [CH_W-1:0]              o_ch;

  modport master (
    output i_req, i_data, i_clear,
    input  o_grant, o_ce, o_data, o_ch
  );

  modport slave (
    input  i_req, i_data, i_clear,
    output o_grant, o_ce, o_data, o_ch
  );
endinterface

// File: rtl/average_filter_scheduler_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant, registered priority pointer.
module rr_arbiter
  import average_filter_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N-1:0]           req_i,
  input  logic                   adv_i,
  output logic [N-1:0]           grant_o,
  output logic [ch_width(N)-1:0] idx_o,
  output logic [ch_width(N)-1:0] ptr_o
);
  localparam int unsigned PW = ch_width(N);

  logic [PW-1:0] ptr_q, ptr_d;
  logic [N-1:0]  grant_c;
  logic [PW-1:0] idx_c;
  logic          found_c;
  int unsigned   c;

  // First requester at or after ptr, wrapping past N-1; pointer moves past the winner.
  always_comb begin
    grant_c = '0;
    idx_c   = '0;
    found_c = 1'b0;
    c       = 0;
    for (int unsigned k = 0; k < N; k++) begin
      c = 32'(ptr_q) + k;
      if (c >= N) c = c - N;
      if (!found_c && req_i[PW'(c)]) begin
        found_c           = 1'b1;
        grant_c[PW'(c)]   = 1'b1;
        idx_c             = PW'(c);
      end
    end
    if (reset) begin
      grant_c = '0;
      found_c = 1'b0;
    end
    ptr_d = ptr_q;
    if (adv_i && found_c) ptr_d = (idx_c == PW'(N - 1)) ? '0 : idx_c + PW'(1);
  end

  // Pointer register.
  always_ff @(posedge clk) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

  assign grant_o = grant_c;
  assign idx_o   = idx_c;
  assign ptr_o   = ptr_q;
endmodule

// File: rtl/average_filter_scheduler.sv
// Shares one two-tap (cur + prev) >>> 1 datapath across NUM_CH sample sources.
module average_filter_scheduler
  import average_filter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned NUM_CH     = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  average_filter_scheduler_if.slave bus
);
  localparam int unsigned CH_W = ch_width(NUM_CH);
  localparam int unsigned SW   = DATA_WIDTH + 1;

  logic [NUM_CH-1:0]            grant;
  logic [CH_W-1:0]              gnt_idx;
  logic [CH_W-1:0]              arb_ptr_unused;
  logic                         gnt_any;

  logic signed [DATA_WIDTH-1:0] samples [NUM_CH];
  logic signed [DATA_WIDTH-1:0] cur;
  logic signed [DATA_WIDTH-1:0] hist_rd;

  logic signed [DATA_WIDTH-1:0] hist_q [NUM_CH];
  logic signed [DATA_WIDTH-1:0] hist_d [NUM_CH];
  logic signed [SW-1:0]         sum_q, sum_d;
  logic [CH_W-1:0]              ch_q, ch_d;
  logic                         sum_ce_q, sum_ce_d;
  logic [DATA_WIDTH-1:0]        o_data_q, o_data_d;
  logic [CH_W-1:0]              o_ch_q, o_ch_d;
  logic                         o_ce_q, o_ce_d;

  // No output backpressure, so every grant is consumed and may advance the pointer.
  rr_arbiter #(.N(NUM_CH)) u_arb (
    .clk     (clk),
    .reset   (reset),
    .req_i   (bus.i_req),
    .adv_i   (1'b1),
    .grant_o (grant),
    .idx_o   (gnt_idx),
    .ptr_o   (arb_ptr_unused)
  );

  assign gnt_any = |grant;

  // Next state: history write (wins over clear), sum stage, output stage.
  always_comb begin
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      samples[k] = bus.i_data[k*DATA_WIDTH +: DATA_WIDTH];
    end
    cur     = samples[gnt_idx];
    hist_rd = bus.i_clear ? '0 : hist_q[gnt_idx];

    hist_d = hist_q;
    if (bus.i_clear) begin
      for (int unsigned k = 0; k < NUM_CH; k++) hist_d[k] = '0;
    end
    if (gnt_any) hist_d[gnt_idx] = cur;

    sum_ce_d = gnt_any;
    sum_d    = sum_q;
    ch_d     = ch_q;
    if (gnt_any) begin
      sum_d = {cur[DATA_WIDTH-1], cur} + {hist_rd[DATA_WIDTH-1], hist_rd};
      ch_d  = gnt_idx;
    end

    o_ce_d   = sum_ce_q;
    o_data_d = o_data_q;
    o_ch_d   = o_ch_q;
    if (sum_ce_q) begin
      o_data_d = sum_q[DATA_WIDTH:1];
      o_ch_d   = ch_q;
    end
  end

  // State registers; reset discards everything in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned k = 0; k < NUM_CH; k++) hist_q[k] <= '0;
      sum_q    <= '0;
      ch_q     <= '0;
      sum_ce_q <= 1'b0;
      o_data_q <= '0;
      o_ch_q   <= '0;
      o_ce_q   <= 1'b0;
    end else begin
      hist_q   <= hist_d;
      sum_q    <= sum_d;
      ch_q     <= ch_d;
      sum_ce_q <= sum_ce_d;
      o_data_q <= o_data_d;
      o_ch_q   <= o_ch_d;
      o_ce_q   <= o_ce_d;
    end
  end

  assign bus.o_grant = grant;
  assign bus.o_ce    = o_ce_q;
  assign bus.o_data  = o_data_q;
  assign bus.o_ch    = o_ch_q;
endmodule

// File: tb/tb_average_filter_scheduler.sv
// Scoreboard bench for average_filter_scheduler: directed scenarios plus random traffic.
module tb_average_filter_scheduler;
  import average_filter_pkg::*;

  localparam int unsigned DW  = 8;
  localparam int unsigned NCH = 4;

  typedef struct {
    int ch;
    int data;
    int due;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  average_filter_scheduler_if #(.DATA_WIDTH(DW), .NUM_CH(NCH)) bus ();

  average_filter_scheduler #(.DATA_WIDTH(DW), .NUM_CH(NCH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  exp_t q[$];
  int   cyc    = 0;
  int   n_vec  = 0;
  int   n_err  = 0;
  int   zchk   = -1;
  int   m_ptr  = 0;
  int   m_hist [NCH];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [NCH*DW-1:0] pk(input int d0, input int d1, input int d2, input int d3);
    return {DW'(d3), DW'(d2), DW'(d1), DW'(d0)};
  endfunction

  // Monitor: pops the scoreboard whenever a result strobe is seen.
  always @(negedge clk) begin
    exp_t e;
    if (cyc == zchk) begin
      check("reset_o_ce", int'(bus.o_ce), 0);
      check("reset_o_data", int'(bus.o_data), 0);
      check("reset_o_ch", int'(bus.o_ch), 0);
    end
    while (q.size() > 0 && q[0].due < cyc) begin
      n_vec++;
      n_err++;
      $display("FAIL missing_result: got none expected ch%0d=%0d (due cycle %0d)",
               q[0].ch, q[0].data, q[0].due);
      void'(q.pop_front());
    end
    if (bus.o_ce === 1'b1) begin
      if (q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_result: got ch%0d=%0d expected no result (cycle %0d)",
                 bus.o_ch, $signed(bus.o_data), cyc);
      end else begin
        e = q.pop_front();
        check("o_ch", int'(bus.o_ch), e.ch);
        check("o_data", int'($signed(bus.o_data)), e.data);
        check("latency", cyc, e.due);
      end
    end
  end

  // One cycle of stimulus; reference model picks the winner and predicts the result.
  task automatic step(input logic [NCH-1:0] req, input logic [NCH*DW-1:0] data,
                      input logic clr, input logic rst, output int g);
    int cur;
    int prev;
    @(negedge clk);
    #1;
    bus.i_req   = req;
    bus.i_data  = data;
    bus.i_clear = clr;
    reset       = rst;
    #1;
    g = -1;
    if (!rst) begin
      for (int k = 0; k < NCH; k++) begin
        int c = (m_ptr + k) % NCH;
        if (g < 0 && req[c]) g = c;
      end
    end
    check("o_grant", int'(bus.o_grant), (g < 0) ? 0 : (1 << g));
    if (rst) begin
      m_ptr = 0;
      for (int k = 0; k < NCH; k++) m_hist[k] = 0;
      q.delete();
      zchk = cyc + 1;
    end else begin
      cur = 0;
      if (g >= 0) begin
        cur  = int'($signed(data[g*DW +: DW]));
        prev = clr ? 0 : m_hist[g];
        q.push_back('{g, (cur + prev) >>> 1, cyc + 2});
        m_ptr = (g + 1) % NCH;
      end
      if (clr) for (int k = 0; k < NCH; k++) m_hist[k] = 0;
      if (g >= 0) m_hist[g] = cur;
    end
  endtask

  initial begin
    int g;
    int t1 [3];
    logic [NCH-1:0]    rq;
    logic [NCH*DW-1:0] dd;

    reset       = 1'b1;
    bus.i_req   = '0;
    bus.i_data  = '0;
    bus.i_clear = 1'b0;
    for (int k = 0; k < NCH; k++) m_hist[k] = 0;

    repeat (3) step('0, '0, 1'b0, 1'b1, g);

    // Single channel: 10, 20, -6 -> 5, 15, 7.
    t1 = '{10, 20, -6};
    for (int i = 0; i < 3; i++) begin
      step(4'b0001, pk(t1[i], 0, 0, 0), 1'b0, 1'b0, g);
      step('0, '0, 1'b0, 1'b0, g);
    end
    repeat (3) step('0, '0, 1'b0, 1'b0, g);

    // All channels continuously: strict rotation, one result every cycle.
    for (int i = 0; i < 12; i++) begin
      step(4'b1111, pk($urandom, $urandom, $urandom, $urandom), 1'b0, 1'b0, g);
    end
    step('0, '0, 1'b1, 1'b0, g);

    // Channel isolation: ch1 100,100 and ch2 -100,-100 interleaved.
    for (int i = 0; i < 2; i++) begin
      step(4'b0010, pk(0, 100, 0, 0), 1'b0, 1'b0, g);
      step(4'b0100, pk(0, 0, -100, 0), 1'b0, 1'b0, g);
    end
    step('0, '0, 1'b1, 1'b0, g);

    // Extremes and floor rounding.
    step(4'b0001, pk(-1, 0, 0, 0), 1'b0, 1'b0, g);
    step(4'b0010, pk(0, 127, 0, 0), 1'b0, 1'b0, g);
    step(4'b0010, pk(0, 127, 0, 0), 1'b0, 1'b0, g);
    step(4'b0100, pk(0, 0, -128, 0), 1'b0, 1'b0, g);
    step(4'b0100, pk(0, 0, -128, 0), 1'b0, 1'b0, g);

    // Clear colliding with a grant: write wins, sum uses zero history.
    step(4'b1000, pk(0, 0, 0, 40), 1'b0, 1'b0, g);
    step(4'b1000, pk(0, 0, 0, 20), 1'b1, 1'b0, g);
    step(4'b1000, pk(0, 0, 0, 20), 1'b0, 1'b0, g);
    step(4'b0001, pk(8, 0, 0, 0), 1'b0, 1'b0, g);
    repeat (3) step('0, '0, 1'b0, 1'b0, g);

    // Reset with a full pipeline, then ch2 alone.
    for (int i = 0; i < 4; i++) begin
      step(4'b1111, pk($urandom, $urandom, $urandom, $urandom), 1'b0, 1'b0, g);
    end
    step(4'b1111, pk(1, 2, 3, 4), 1'b0, 1'b1, g);
    step(4'b0100, pk(0, 0, 6, 0), 1'b0, 1'b0, g);
    repeat (3) step('0, '0, 1'b0, 1'b0, g);

    // Random traffic with drops, clears and occasional resets.
    rq = '0;
    dd = '0;
    for (int i = 0; i < 3000; i++) begin
      for (int k = 0; k < NCH; k++) begin
        if (!rq[k] && ($urandom % 3 == 0)) begin
          rq[k]          = 1'b1;
          dd[k*DW +: DW] = DW'($urandom);
        end else if (rq[k] && ($urandom % 16 == 0)) begin
          rq[k] = 1'b0;
        end
      end
      step(rq, dd, ($urandom % 20 == 0), ($urandom % 200 == 0), g);
      if (g >= 0) rq[g] = 1'b0;
    end

    repeat (4) step('0, '0, 1'b0, 1'b0, g);
    if (q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: got %0d results outstanding expected 0", q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
